// File: rtl/uart_ctrl_if.sv
// rtl/uart_ctrl_if.sv - simple MMIO read/write port used by uart_ctrl
interface uart_ctrl_if;
   logic [31:0] raddr;
   logic [31:0] rdata;
   logic        rvalid;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        wvalid;

   modport master (output raddr, rvalid, waddr, wdata, wvalid, input rdata);
   modport slave  (input raddr, rvalid, waddr, wdata, wvalid, output rdata);
endinterface

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - memory-mapped UART with rx/tx FIFOs, sticky status flags and level irq
module uart_fifo #(
   parameter int AW = 6
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        push_i,
   input  logic [7:0]  data_i,
   input  logic        pop_i,
   output logic [7:0]  head_o,
   output logic [AW:0] level_o,
   output logic        empty_o,
   output logic        full_o
);
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [7:0]    mem_q [2**AW];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == DEPTH);
   assign do_pop  = pop_i & ~empty_o;
   // a pop on a full FIFO frees the slot the same-cycle push lands in
   assign do_push = push_i & (~full_o | do_pop);
   assign head_o  = mem_q[rptr_q];
   assign level_o = cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end
endmodule

module uart_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'ha00003f8,
   parameter int          FIFO_AW     = 6,
   parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
   input  logic       clock_i,
   input  logic       reset_ni,
   uart_ctrl_if.slave bus,
   input  logic       rx_i,
   output logic       tx_o,
   output logic       irq_o
);
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_e;

   logic [31:0] roff, woff, status;
   logic        r_in, w_in, rd_data, wr_data, wr_stat, wr_div, wr_ctrl;
   logic [15:0] div_q, div_d;
   logic [7:0]  ctrl_q, ctrl_d;
   logic [3:0]  flags_q, flags_d;
   logic        irq_q, irq_d;
   logic        set_over, set_frame, set_par, set_drop;
   logic        unused_ok;

   logic [7:0]       rx_head, tx_head;
   logic [FIFO_AW:0] rx_level, tx_level;
   logic             rx_empty, rx_full, tx_empty, tx_full, rx_push, tx_pop;

   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic        tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_two_q, tx_two_d, tx_tick;

   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic        rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
   logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall, rx_tick, rx_half;

   // subtracting the base keeps the window correct for non-16-aligned BASE_ADDR
   assign roff    = bus.raddr - BASE_ADDR;
   assign woff    = bus.waddr - BASE_ADDR;
   assign r_in    = (roff < 32'd16);
   assign w_in    = (woff < 32'd16);
   assign rd_data = bus.rvalid & r_in & (roff[3:0] == 4'h0);
   assign wr_data = bus.wvalid & w_in & (woff[3:0] == 4'h0);
   assign wr_stat = bus.wvalid & w_in & (woff[3:0] == 4'h4);
   assign wr_div  = bus.wvalid & w_in & (woff[3:0] == 4'h8);
   assign wr_ctrl = bus.wvalid & w_in & (woff[3:0] == 4'hC);
   assign unused_ok = ^bus.wdata[31:16];

   uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
      .clk_i(clock_i), .rst_ni(reset_ni), .push_i(rx_push), .data_i(rx_sh_q),
      .pop_i(rd_data), .head_o(rx_head), .level_o(rx_level),
      .empty_o(rx_empty), .full_o(rx_full));

   uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
      .clk_i(clock_i), .rst_ni(reset_ni), .push_i(wr_data), .data_i(bus.wdata[7:0]),
      .pop_i(tx_pop), .head_o(tx_head), .level_o(tx_level),
      .empty_o(tx_empty), .full_o(tx_full));

   always_comb begin
      status = '0;
      status[4:0] = {tx_state_q != TX_IDLE, tx_full, tx_empty, rx_full, rx_empty};
      status[8:5] = flags_q;
      status[16 +: FIFO_AW+1] = rx_level;
      status[24 +: FIFO_AW+1] = tx_level;
   end

   always_comb begin
      bus.rdata = '0;
      if (r_in) begin
         case (roff[3:0])
            4'h0:    bus.rdata = rx_empty ? 32'hff : {24'b0, rx_head};
            4'h4:    bus.rdata = status;
            4'h8:    bus.rdata = {16'b0, div_q};
            4'hC:    bus.rdata = {24'b0, ctrl_q};
            default: bus.rdata = '0;
         endcase
      end
   end

   assign set_over = rx_push & rx_full & ~rd_data;
   assign set_drop = wr_data & tx_full & ~tx_pop;

   always_comb begin
      div_d  = div_q;
      ctrl_d = ctrl_q;
      if (wr_div)  div_d  = (bus.wdata[15:0] < 16'd3) ? 16'd3 : bus.wdata[15:0];
      if (wr_ctrl) ctrl_d = bus.wdata[7:0];
      flags_d = flags_q & ~(wr_stat ? bus.wdata[8:5] : 4'b0);
      flags_d = flags_d | {set_drop, set_par, set_frame, set_over};
      irq_d   = (ctrl_q[5] & ~rx_empty) | (ctrl_q[6] & tx_empty) | (ctrl_q[7] & |flags_q);
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         div_q   <= DEFAULT_DIV;
         ctrl_q  <= 8'h03;
         flags_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         div_q   <= div_d;
         ctrl_q  <= ctrl_d;
         flags_q <= flags_d;
         irq_q   <= irq_d;
      end
   end
   assign irq_o = irq_q;

   assign tx_tick = (tx_cnt_q == tx_div_q);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + 16'd1;
      tx_div_d   = tx_div_q;
      tx_sh_d    = tx_sh_q;
      tx_bit_d   = tx_bit_q;
      tx_par_d   = tx_par_q;
      tx_pen_d   = tx_pen_q;
      tx_two_d   = tx_two_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (ctrl_q[1] && !tx_empty) begin
               tx_pop     = 1'b1;
               tx_sh_d    = tx_head;
               tx_div_d   = div_q;
               tx_pen_d   = ctrl_q[2];
               tx_par_d   = ^tx_head ^ ctrl_q[3];
               tx_two_d   = ctrl_q[4];
               tx_bit_d   = '0;
               tx_state_d = TX_START;
            end
         end
         TX_START: if (tx_tick) tx_state_d = TX_DATA;
         TX_DATA: if (tx_tick) begin
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = tx_pen_q ? TX_PARITY : TX_STOP;
         end
         TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
         TX_STOP: if (tx_tick) begin
            // two_stop doubles as the "one more stop bit pending" marker
            if (tx_two_q) tx_two_d = 1'b0;
            else          tx_state_d = TX_IDLE;
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      case (tx_state_q)
         TX_START:  tx_o = 1'b0;
         TX_DATA:   tx_o = tx_sh_q[0];
         TX_PARITY: tx_o = tx_par_q;
         default:   tx_o = 1'b1;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_div_q   <= DEFAULT_DIV;
         tx_sh_q    <= '0;
         tx_bit_q   <= '0;
         tx_par_q   <= 1'b0;
         tx_pen_q   <= 1'b0;
         tx_two_q   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         tx_sh_q    <= tx_sh_d;
         tx_bit_q   <= tx_bit_d;
         tx_par_q   <= tx_par_d;
         tx_pen_q   <= tx_pen_d;
         tx_two_q   <= tx_two_d;
      end
   end

   assign rx_fall = rx_prev_q & ~rx_s2_q;
   assign rx_tick = (rx_cnt_q == rx_div_q);
   assign rx_half = (rx_cnt_q == {1'b0, rx_div_q[15:1]});

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 16'd1;
      rx_div_d   = rx_div_q;
      rx_sh_d    = rx_sh_q;
      rx_bit_d   = rx_bit_q;
      rx_pen_d   = rx_pen_q;
      rx_odd_d   = rx_odd_q;
      rx_perr_d  = rx_perr_q;
      rx_push    = 1'b0;
      set_frame  = 1'b0;
      set_par    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (ctrl_q[0] && rx_fall) begin
               rx_div_d   = div_q;
               rx_pen_d   = ctrl_q[2];
               rx_odd_d   = ctrl_q[3];
               rx_perr_d  = 1'b0;
               rx_bit_d   = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: if (rx_half) begin
            rx_cnt_d   = '0;
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_tick) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
         end
         RX_PARITY: if (rx_tick) begin
            rx_cnt_d   = '0;
            rx_perr_d  = rx_s2_q ^ (^rx_sh_q) ^ rx_odd_q;
            rx_state_d = RX_STOP;
         end
         RX_STOP: if (rx_tick) begin
            rx_cnt_d = '0;
            if (!rx_s2_q) begin
               set_frame  = 1'b1;
               rx_state_d = RX_WAIT;
            end else begin
               set_par    = rx_perr_q;
               rx_push    = ~rx_perr_q;
               rx_state_d = RX_IDLE;
            end
         end
         RX_WAIT: begin
            rx_cnt_d = '0;
            if (rx_s2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_div_q   <= DEFAULT_DIV;
         rx_sh_q    <= '0;
         rx_bit_q   <= '0;
         rx_pen_q   <= 1'b0;
         rx_odd_q   <= 1'b0;
         rx_perr_q  <= 1'b0;
      end else begin
         rx_s1_q    <= rx_i;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         rx_sh_q    <= rx_sh_d;
         rx_bit_q   <= rx_bit_d;
         rx_pen_q   <= rx_pen_d;
         rx_odd_q   <= rx_odd_d;
         rx_perr_q  <= rx_perr_d;
      end
   end
endmodule
